// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encodings and defaults for the stopwatch controller
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSE  = 2'b10,
        ST_ADJUST = 2'b11
    } state_t;

    localparam int LOCKOUT_DEFAULT = 1000;

endpackage

// File: rtl/edge_pulse.sv
// rtl/edge_pulse.sv - rising-edge detector on a debounced button level
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_pulse
);

    // Previous sample resets high so a button held through reset is not an event
    logic r_prev;

    // Track the level every cycle, including while the controller is locked out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_pulse = i_level & ~r_prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - mode FSM, button arbitration and lockout for a stopwatch
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int LOCK_W  = 16,
    parameter int LOCKOUT = LOCKOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_clear,
    input  logic       btn_pause,
    input  logic       btn_sel,
    input  logic       sw_adj,
    input  logic       tick,
    output logic       count_en,
    output logic       clear,
    output logic       adj_inc,
    output logic       adj_sel,
    output logic [1:0] state
);

    logic              w_ev_clear;
    logic              w_ev_pause;
    logic              w_ev_sel;
    logic              w_open;
    logic              w_take_clear;
    logic              w_take_pause;
    logic              w_take_sel;

    state_t            r_state;
    logic [LOCK_W-1:0] r_lock;
    logic              r_count_en;
    logic              r_clear;
    logic              r_adj_inc;
    logic              r_adj_sel;

    edge_pulse u_edge_clear (.clk(clk), .rst(rst), .i_level(btn_clear), .o_pulse(w_ev_clear));
    edge_pulse u_edge_pause (.clk(clk), .rst(rst), .i_level(btn_pause), .o_pulse(w_ev_pause));
    edge_pulse u_edge_sel   (.clk(clk), .rst(rst), .i_level(btn_sel),   .o_pulse(w_ev_sel));

    // Fixed priority picks one winning event; a winner that is meaningless in the
    // current mode is dropped and does not arm the lockout, and losers are never queued.
    assign w_open       = (r_lock == '0);
    assign w_take_clear = w_open & w_ev_clear;
    assign w_take_pause = w_open & ~w_ev_clear & w_ev_pause & (r_state != ST_ADJUST);
    assign w_take_sel   = w_open & ~w_ev_clear & ~w_ev_pause & w_ev_sel & (r_state == ST_ADJUST);

    // Mode FSM, lockout counter and registered strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_lock     <= '0;
            r_count_en <= 1'b0;
            r_clear    <= 1'b0;
            r_adj_inc  <= 1'b0;
            r_adj_sel  <= 1'b0;
        end else begin
            r_clear    <= w_take_clear;
            r_count_en <= tick & (r_state == ST_RUN) & ~w_take_clear;
            r_adj_inc  <= tick & (r_state == ST_ADJUST);

            if (w_take_clear | w_take_pause | w_take_sel) begin
                r_lock <= LOCK_W'(LOCKOUT);
            end else if (!w_open) begin
                r_lock <= r_lock - LOCK_W'(1);
            end

            if (w_take_sel) begin
                r_adj_sel <= ~r_adj_sel;
            end

            if (w_take_clear) begin
                r_state   <= ST_IDLE;
                r_adj_sel <= 1'b0;
            end else if (w_take_pause) begin
                r_state <= (r_state == ST_RUN) ? ST_PAUSE : ST_RUN;
            end else begin
                // The adjust switch is a level: it pulls IDLE/PAUSE into ADJUST and
                // releases ADJUST back to PAUSE, but never interrupts RUN.
                case (r_state)
                    ST_IDLE, ST_PAUSE: if (sw_adj)  r_state <= ST_ADJUST;
                    ST_ADJUST:         if (!sw_adj) r_state <= ST_PAUSE;
                    default:           r_state <= r_state;
                endcase
            end
        end
    end

    assign count_en = r_count_en;
    assign clear    = r_clear;
    assign adj_inc  = r_adj_inc;
    assign adj_sel  = r_adj_sel;
    assign state    = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl against a behavioural model
module tb_stopwatch_ctrl;

    localparam int LOCK_W  = 16;
    localparam int LOCKOUT = 4;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSE  = 2;
    localparam int M_ADJUST = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_clear = 1'b0;
    logic       btn_pause = 1'b0;
    logic       btn_sel = 1'b0;
    logic       sw_adj = 1'b0;
    logic       tick = 1'b0;
    logic       count_en;
    logic       clear;
    logic       adj_inc;
    logic       adj_sel;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;
    int n_count_seen = 0;
    int n_inc_seen = 0;

    // Behavioural model: mode as plain integer, lockout as a cycle countdown
    int m_mode;
    int m_lock;
    bit m_prev_c, m_prev_p, m_prev_s;
    bit m_sel, m_cnt, m_clr, m_inc;

    stopwatch_ctrl #(.LOCK_W(LOCK_W), .LOCKOUT(LOCKOUT)) dut (
        .clk(clk), .rst(rst),
        .btn_clear(btn_clear), .btn_pause(btn_pause), .btn_sel(btn_sel),
        .sw_adj(sw_adj), .tick(tick),
        .count_en(count_en), .clear(clear), .adj_inc(adj_inc),
        .adj_sel(adj_sel), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_lock = 0;
        m_prev_c = 1; m_prev_p = 1; m_prev_s = 1;
        m_sel = 0; m_cnt = 0; m_clr = 0; m_inc = 0;
    endtask

    // One clock edge of the stopwatch rules, given the inputs sampled at that edge
    task automatic model_edge(input bit c, input bit p, input bit s, input bit a, input bit t);
        bit ec, ep, es, moved;
        ec = c && !m_prev_c;
        ep = p && !m_prev_p;
        es = s && !m_prev_s;
        m_prev_c = c; m_prev_p = p; m_prev_s = s;
        m_cnt = t && (m_mode == M_RUN);
        m_inc = t && (m_mode == M_ADJUST);
        m_clr = 0;
        moved = 0;
        if (m_lock > 0) begin
            m_lock = m_lock - 1;
        end else if (ec) begin
            m_clr = 1; m_cnt = 0; m_mode = M_IDLE; m_sel = 0;
            m_lock = LOCKOUT; moved = 1;
        end else if (ep) begin
            if (m_mode != M_ADJUST) begin
                m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
                m_lock = LOCKOUT; moved = 1;
            end
        end else if (es) begin
            if (m_mode == M_ADJUST) begin
                m_sel = !m_sel;
                m_lock = LOCKOUT;
            end
        end
        if (!moved) begin
            if ((m_mode == M_IDLE || m_mode == M_PAUSE) && a) m_mode = M_ADJUST;
            else if (m_mode == M_ADJUST && !a)                 m_mode = M_PAUSE;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},    32'(state),    32'(m_mode));
        chk({tag, ".count_en"}, 32'(count_en), 32'(m_cnt));
        chk({tag, ".clear"},    32'(clear),    32'(m_clr));
        chk({tag, ".adj_inc"},  32'(adj_inc),  32'(m_inc));
        chk({tag, ".adj_sel"},  32'(adj_sel),  32'(m_sel));
    endtask

    // Drive inputs just after a falling edge, advance one cycle, check at the next falling edge
    task automatic step(input string tag, input bit c, input bit p, input bit s, input bit a, input bit t);
        btn_clear = c; btn_pause = p; btn_sel = s; sw_adj = a; tick = t;
        model_edge(c, p, s, a, t);
        @(negedge clk);
        if (count_en) n_count_seen++;
        if (adj_inc)  n_inc_seen++;
        check_all(tag);
    endtask

    task automatic idle_steps(input int n, input bit a);
        for (int i = 0; i < n; i++) step("idle", 1'b0, 1'b0, 1'b0, a, 1'b0);
    endtask

    initial begin
        bit rc, rp, rs, ra, rt;

        // Reset state
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.count_en", 32'(count_en), 32'd0);
        chk("rst.clear", 32'(clear), 32'd0);
        chk("rst.adj_inc", 32'(adj_inc), 32'd0);
        chk("rst.adj_sel", 32'(adj_sel), 32'd0);
        rst = 1'b0;

        // First pause event starts RUN, re-pulse inside lockout is ignored
        step("p_lo", 0, 0, 0, 0, 0);
        step("p_rise", 0, 1, 0, 0, 0);
        chk("run_entry", 32'(state), 32'd1);
        step("p_lo2", 0, 0, 0, 0, 0);
        step("p_repulse", 0, 1, 0, 0, 0);
        chk("lockout_ignore", 32'(state), 32'd1);
        idle_steps(6, 0);

        // Three ticks in RUN give three count strobes
        n_count_seen = 0;
        for (int i = 0; i < 3; i++) begin
            step("run_tick", 0, 0, 0, 0, 1);
            chk("count_after_tick", 32'(count_en), 32'd1);
            step("run_gap", 0, 0, 0, 0, 0);
        end
        chk("count_total", 32'(n_count_seen), 32'd3);

        // Pause, then ticks produce nothing
        step("to_pause", 0, 1, 0, 0, 0);
        chk("pause_entry", 32'(state), 32'd2);
        idle_steps(6, 0);
        n_count_seen = 0;
        for (int i = 0; i < 3; i++) step("pause_tick", 0, 0, 0, 0, 1);
        step("pause_gap", 0, 0, 0, 0, 0);
        chk("pause_no_count", 32'(n_count_seen), 32'd0);

        // Adjust mode: field select, increment, release
        step("adj_on", 0, 0, 0, 1, 0);
        chk("adjust_entry", 32'(state), 32'd3);
        step("sel_rise", 0, 0, 1, 1, 0);
        chk("sel_toggle", 32'(adj_sel), 32'd1);
        step("sel_lo", 0, 0, 0, 1, 0);
        step("adj_tick", 0, 0, 0, 1, 1);
        chk("adj_inc_pulse", 32'(adj_inc), 32'd1);
        step("adj_off", 0, 0, 0, 0, 0);
        chk("adjust_exit", 32'(state), 32'd2);
        idle_steps(6, 0);

        // Back to RUN, then clear+pause+tick together: only clear happens
        step("resume", 0, 1, 0, 0, 0);
        chk("resume_run", 32'(state), 32'd1);
        step("resume_lo", 0, 0, 0, 0, 0);
        idle_steps(5, 0);
        step("clr_pause", 1, 1, 0, 0, 1);
        chk("clr_state", 32'(state), 32'd0);
        chk("clr_strobe", 32'(clear), 32'd1);
        chk("clr_no_count", 32'(count_en), 32'd0);
        step("clr_after", 0, 0, 0, 0, 0);
        chk("clr_one_cycle", 32'(clear), 32'd0);
        chk("clr_no_pause", 32'(state), 32'd0);
        idle_steps(6, 0);

        // Button held through reset release is not an event
        rst = 1'b1;
        btn_pause = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step("held_pause", 0, 1, 0, 0, 0);
        chk("held_no_event", 32'(state), 32'd0);

        // Asynchronous reset in the middle of RUN with a count strobe pending high
        step("rel", 0, 0, 0, 0, 0);
        step("go", 0, 1, 0, 0, 0);
        idle_steps(6, 0);
        step("go_tick", 0, 0, 0, 0, 1);
        chk("pre_async_count", 32'(count_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async.state", 32'(state), 32'd0);
        chk("async.count_en", 32'(count_en), 32'd0);
        chk("async.clear", 32'(clear), 32'd0);
        chk("async.adj_inc", 32'(adj_inc), 32'd0);
        chk("async.adj_sel", 32'(adj_sel), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomized run against the model
        rc = 0; rp = 0; rs = 0; ra = 0; rt = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0)  rc = !rc;
            if ($urandom_range(0, 3) == 0)  rp = !rp;
            if ($urandom_range(0, 3) == 0)  rs = !rs;
            if ($urandom_range(0, 19) == 0) ra = !ra;
            rt = ($urandom_range(0, 2) == 0);
            step("rand", rc, rp, rs, ra, rt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
